// File: rtl/int_freelist_ctrl_if.sv
// int_freelist_ctrl_if: rename/commit side bundle for the integer physical register free list.
// master = rename/commit/RAT side, slave = free list.
// alloc: i_alloc_req -> o_alloc_rdy, o_alloc_prd_idx; status: o_free_count
// commit: i_commit_vld, i_commit_alloc; release: i_dealloc_vld, i_dealloc_prd_idx; i_squash_vld
interface int_freelist_ctrl_if #(
    parameter int NUM_PHYREG = 64,
    parameter int WIDTH = 4,
    parameter int COMMIT_WID = 4,
    parameter int PR_W = $clog2(NUM_PHYREG)
);
    logic [WIDTH-1:0] i_alloc_req;
    logic o_alloc_rdy;
    logic [WIDTH-1:0][PR_W-1:0] o_alloc_prd_idx;
    logic [PR_W:0] o_free_count;
    logic [COMMIT_WID-1:0] i_commit_vld;
    logic [COMMIT_WID-1:0] i_commit_alloc;
    logic [COMMIT_WID-1:0] i_dealloc_vld;
    logic [COMMIT_WID-1:0][PR_W-1:0] i_dealloc_prd_idx;
    logic i_squash_vld;
    modport master (
        output i_alloc_req, i_commit_vld, i_commit_alloc, i_dealloc_vld, i_dealloc_prd_idx, i_squash_vld,
        input o_alloc_rdy, o_alloc_prd_idx, o_free_count
    );
    modport slave (
        input i_alloc_req, i_commit_vld, i_commit_alloc, i_dealloc_vld, i_dealloc_prd_idx, i_squash_vld,
        output o_alloc_rdy, o_alloc_prd_idx, o_free_count
    );
endinterface

// File: rtl/int_freelist_ctrl.sv
// int_freelist_ctrl: integer physical register free list with spec/arch heads and one-cycle squash recovery.
// clk, rst_n (async, active-low); bus (slave): alloc request/grant, commit, dealloc, squash, free count.
module int_freelist_ctrl #(
    parameter int NUM_PHYREG = 64,
    parameter int WIDTH = 4,
    parameter int COMMIT_WID = 4,
    parameter int PR_W = $clog2(NUM_PHYREG)
) (
    input logic clk,
    input logic rst_n,
    int_freelist_ctrl_if.slave bus
);
    localparam int CNT_W = PR_W + 1;
    logic [PR_W-1:0] entry_q [NUM_PHYREG];
    logic [PR_W-1:0] entry_d [NUM_PHYREG];
    logic [CNT_W-1:0] spec_head_q, spec_head_d, arch_head_q, arch_head_d, tail_q, tail_d;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic [CNT_W-1:0] spec_cnt, arch_cnt, spec_arch, n_req, n_commit, n_dealloc;
    logic [PR_W-1:0] alloc_k, dealloc_k;
    logic [COMMIT_WID-1:0] zero_rel;
    logic rdy, fire;
    always_comb begin
        spec_cnt = tail_q - spec_head_q;
        arch_cnt = tail_q - arch_head_q;
        spec_arch = spec_head_q - arch_head_q;
        n_req = CNT_W'($countones(bus.i_alloc_req));
        n_commit = CNT_W'($countones(bus.i_commit_vld & bus.i_commit_alloc));
        n_dealloc = CNT_W'($countones(bus.i_dealloc_vld));
        // readiness ignores n_req so there is no req->rdy combinational path
        rdy = spec_cnt >= CNT_W'(WIDTH) && !bus.i_squash_vld;
        fire = rdy && n_req != '0;
        arch_head_d = arch_head_q + n_commit;
        spec_head_d = bus.i_squash_vld ? arch_head_d : fire ? spec_head_q + n_req : spec_head_q;
        tail_d = tail_q + n_dealloc;
        free_cnt_d = tail_d - spec_head_d;
    end
    // requested slots are compacted onto consecutive entries; idle slots show their positional entry
    always_comb begin
        alloc_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bus.o_alloc_prd_idx[i] = entry_q[spec_head_q[PR_W-1:0] + (bus.i_alloc_req[i] ? alloc_k : PR_W'(i))];
            alloc_k = alloc_k + PR_W'(bus.i_alloc_req[i]);
        end
    end
    always_comb begin
        entry_d = entry_q;
        dealloc_k = '0;
        for (int i = 0; i < COMMIT_WID; i++) begin
            if (bus.i_dealloc_vld[i]) entry_d[tail_q[PR_W-1:0] + dealloc_k] = bus.i_dealloc_prd_idx[i];
            zero_rel[i] = bus.i_dealloc_vld[i] && bus.i_dealloc_prd_idx[i] == '0;
            dealloc_k = dealloc_k + PR_W'(bus.i_dealloc_vld[i]);
        end
    end
    assign bus.o_alloc_rdy = rdy;
    assign bus.o_free_count = free_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_PHYREG; k++) entry_q[k] <= (k == NUM_PHYREG - 1) ? '0 : PR_W'(k + 1);
            spec_head_q <= '0;
            arch_head_q <= '0;
            tail_q <= CNT_W'(NUM_PHYREG - 1);
            free_cnt_q <= CNT_W'(NUM_PHYREG - 1);
        end else begin
            entry_q <= entry_d;
            spec_head_q <= spec_head_d;
            arch_head_q <= arch_head_d;
            tail_q <= tail_d;
            free_cnt_q <= free_cnt_d;
        end
    end
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) arch_cnt <= CNT_W'(NUM_PHYREG - 1));
    a_no_zero_release: assert property (@(posedge clk) disable iff (!rst_n) zero_rel == '0);
    a_spec_le_tail: assert property (@(posedge clk) disable iff (!rst_n) spec_cnt <= CNT_W'(NUM_PHYREG));
    a_arch_le_spec: assert property (@(posedge clk) disable iff (!rst_n)
        bus.i_squash_vld || spec_arch <= CNT_W'(NUM_PHYREG - 1));
endmodule

// File: tb/tb_int_freelist_ctrl.sv
// tb_int_freelist_ctrl: directed + randomized check of int_freelist_ctrl against a queue-based free list model.
module tb_int_freelist_ctrl;
    logic clk, rst_n;
    int n_chk, n_pass, n_fail;
    int free_q[$], alloc_q[$], held_q[$];
    int avail, c, j, n;
    logic [63:0] seen;
    int_freelist_ctrl_if #(.NUM_PHYREG(64), .WIDTH(4), .COMMIT_WID(4)) bus ();
    int_freelist_ctrl #(.NUM_PHYREG(64), .WIDTH(4), .COMMIT_WID(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic idle();
        bus.i_alloc_req = '0;
        bus.i_commit_vld = '0;
        bus.i_commit_alloc = '0;
        bus.i_dealloc_vld = '0;
        bus.i_dealloc_prd_idx = '0;
        bus.i_squash_vld = 0;
    endtask
    task automatic model_reset();
        free_q.delete();
        alloc_q.delete();
        held_q.delete();
        for (int v = 1; v < 64; v++) free_q.push_back(v);
    endtask
    task automatic take(input int v);
        foreach (held_q[k]) if (held_q[k] == v) begin
            held_q.delete(k);
            break;
        end
    endtask
    task automatic reset_checks(input string tag);
        chk({tag, "_free_count"}, 32'(bus.o_free_count), 63);
        chk({tag, "_rdy"}, 32'(bus.o_alloc_rdy), 1);
        for (int i = 0; i < 4; i++) chk({tag, "_prd"}, 32'(bus.o_alloc_prd_idx[i]), 32'(i + 1));
    endtask
    // Called at a negedge with inputs already driven; checks grants, advances the model, checks the count.
    task automatic step();
        logic exp_rdy;
        int k, ncmt;
        #1;
        exp_rdy = free_q.size() >= 4 && !bus.i_squash_vld;
        chk("rdy", 32'(bus.o_alloc_rdy), 32'(exp_rdy));
        k = 0;
        if (exp_rdy) for (int i = 0; i < 4; i++) if (bus.i_alloc_req[i]) begin
            chk("prd", 32'(bus.o_alloc_prd_idx[i]), 32'(free_q[k]));
            k++;
        end
        if (exp_rdy) for (int i = 0; i < 4; i++) if (bus.i_alloc_req[i]) alloc_q.push_back(free_q.pop_front());
        ncmt = $countones(bus.i_commit_vld & bus.i_commit_alloc);
        repeat (ncmt) held_q.push_back(alloc_q.pop_front());
        if (bus.i_squash_vld) while (alloc_q.size() > 0) free_q.push_front(alloc_q.pop_back());
        for (int i = 0; i < 4; i++) if (bus.i_dealloc_vld[i]) free_q.push_back(int'(bus.i_dealloc_prd_idx[i]));
        @(posedge clk);
        #1;
        chk("free_count", 32'(bus.o_free_count), 32'(free_q.size()));
        @(negedge clk);
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle();
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask
    initial begin
        n_chk = 0;
        n_pass = 0;
        n_fail = 0;
        rst_n = 0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1;
        reset_checks("reset");
        @(negedge clk);
        bus.i_alloc_req = 4'b1010;
        step();
        chk("compact_cnt", 32'(bus.o_free_count), 61);
        bus.i_alloc_req = 4'b1111;
        step();
        chk("compact_cnt2", 32'(bus.o_free_count), 57);
        do_reset();
        bus.i_alloc_req = 4'b1111;
        repeat (15) step();
        chk("exh_cnt", 32'(bus.o_free_count), 3);
        chk("exh_rdy", 32'(bus.o_alloc_rdy), 0);
        bus.i_alloc_req = '0;
        bus.i_commit_vld = '1;
        bus.i_commit_alloc = '1;
        repeat (15) step();
        idle();
        bus.i_dealloc_vld = 4'b0011;
        bus.i_dealloc_prd_idx[0] = 6'd7;
        bus.i_dealloc_prd_idx[1] = 6'd9;
        take(7);
        take(9);
        step();
        idle();
        chk("refill_cnt", 32'(bus.o_free_count), 5);
        chk("refill_rdy", 32'(bus.o_alloc_rdy), 1);
        bus.i_alloc_req = 4'b1111;
        #1;
        chk("refill_prd0", 32'(bus.o_alloc_prd_idx[0]), 61);
        chk("refill_prd1", 32'(bus.o_alloc_prd_idx[1]), 62);
        chk("refill_prd2", 32'(bus.o_alloc_prd_idx[2]), 63);
        chk("refill_prd3", 32'(bus.o_alloc_prd_idx[3]), 7);
        step();
        do_reset();
        bus.i_alloc_req = 4'b1111;
        repeat (2) step();
        bus.i_alloc_req = '0;
        bus.i_commit_vld = 4'b0111;
        bus.i_commit_alloc = 4'b0111;
        bus.i_squash_vld = 1;
        step();
        chk("squash_cnt", 32'(bus.o_free_count), 60);
        idle();
        bus.i_alloc_req = 4'b1111;
        step();
        for (int it = 0; it < 200; it++) begin
            idle();
            bus.i_alloc_req = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            bus.i_commit_vld = 4'($urandom);
            bus.i_commit_alloc = 4'($urandom);
            avail = alloc_q.size();
            c = 0;
            for (int i = 0; i < 4; i++) if (bus.i_commit_vld[i] && bus.i_commit_alloc[i]) begin
                if (c < avail) c++;
                else bus.i_commit_alloc[i] = 0;
            end
            bus.i_dealloc_vld = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                bus.i_dealloc_prd_idx[i] = 6'($urandom);
                if (bus.i_dealloc_vld[i] && held_q.size() > 0) begin
                    j = $urandom_range(0, held_q.size() - 1);
                    bus.i_dealloc_prd_idx[i] = 6'(held_q[j]);
                    held_q.delete(j);
                end else bus.i_dealloc_vld[i] = 0;
            end
            bus.i_squash_vld = $urandom_range(0, 15) == 0;
            step();
        end
        idle();
        while (alloc_q.size() > 0) begin
            n = alloc_q.size() > 4 ? 4 : alloc_q.size();
            bus.i_commit_vld = 4'((1 << n) - 1);
            bus.i_commit_alloc = 4'((1 << n) - 1);
            step();
        end
        idle();
        while (held_q.size() > 0) begin
            n = held_q.size() > 4 ? 4 : held_q.size();
            for (int i = 0; i < n; i++) bus.i_dealloc_prd_idx[i] = 6'(held_q.pop_front());
            bus.i_dealloc_vld = 4'((1 << n) - 1);
            step();
        end
        idle();
        chk("drain_cnt", 32'(bus.o_free_count), 63);
        seen = '0;
        bus.i_alloc_req = 4'b1111;
        repeat (15) begin
            #1;
            for (int i = 0; i < 4; i++) seen[bus.o_alloc_prd_idx[i]] = 1'b1;
            step();
        end
        idle();
        bus.i_commit_vld = 4'b1111;
        bus.i_commit_alloc = 4'b1111;
        step();
        idle();
        for (int i = 0; i < 4; i++) bus.i_dealloc_prd_idx[i] = 6'(held_q.pop_front());
        bus.i_dealloc_vld = 4'b1111;
        step();
        idle();
        bus.i_alloc_req = 4'b1111;
        #1;
        for (int i = 0; i < 3; i++) seen[bus.o_alloc_prd_idx[i]] = 1'b1;
        step();
        chk("union_cnt", 32'($countones(seen[63:1])), 63);
        chk("union_no_zero", 32'(seen[0]), 0);
        idle();
        chk("pre_async_cnt", 32'(bus.o_free_count), 3);
        #2;
        rst_n = 0;
        #1;
        reset_checks("async");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        bus.i_alloc_req = 4'b1111;
        step();
        idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
